// File: rtl/pistorm_pkg.sv
// Shared definitions for the 68000 bus responder: widths, synchroniser depth,
// FSM state encoding and the address-window decode.
package pistorm_pkg;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 16;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IGNORE,
    ST_STROBE,
    ST_ACCESS,
    ST_WAIT,
    ST_HOLD,
    ST_RELEASE,
    ST_BERR
  } bus_state_e;

  // a holds address bits [23:1]; base/mask are full byte addresses
  function automatic logic addr_hit(input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W:0]   base,
                                    input logic [ADDR_W:0]   mask);
    return ((({a, 1'b0}) ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchroniser for asynchronous 68000 bus signals. Resets to
// all-ones so the active-low strobes come out of reset deasserted.
module bus_sync
  import pistorm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '1;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/m68k_bus_responder.sv
// Target-side 68000 bus responder: decodes an address window, runs a local
// req/ack transfer and terminates the bus cycle with DTACK, or BERR on timeout.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   IDLE       | waiting for AS; enters ACCESS directly if strobes already low
//   IGNORE     | cycle for another target, wait for AS release
//   STROBE     | hit, waiting for UDS/LDS (late write strobes)
//   ACCESS     | LCL_REQ outstanding, waiting for LCL_ACK
//   WAIT       | MIN_WAIT countdown before DTACK
//   HOLD       | DTACK asserted until AS release
//   RELEASE    | DTACK driven high for one cycle before tri-stating
//   BERR       | BERR asserted until AS release
module m68k_bus_responder
  import pistorm_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'hE80000,
  parameter logic [23:0] ADDR_MASK = 24'hFF0000,
  parameter int          MIN_WAIT  = 2,
  parameter int          TIMEOUT   = 255
) (
  input  logic              PI_CLK,
  input  logic              M68K_RESET_n,
  input  logic [ADDR_W-1:0] M68K_A,
  input  logic              M68K_AS_n,
  input  logic              M68K_UDS_n,
  input  logic              M68K_LDS_n,
  input  logic              M68K_RW,
  input  logic [DATA_W-1:0] M68K_D_IN,
  output logic [DATA_W-1:0] M68K_D_OUT,
  output logic              M68K_D_OE,
  output logic              M68K_DTACK_n,
  output logic              M68K_DTACK_OE,
  output logic              M68K_BERR_n,
  output logic              LCL_REQ,
  output logic              LCL_WE,
  output logic [1:0]        LCL_BE,
  output logic [ADDR_W-1:0] LCL_ADDR,
  output logic [DATA_W-1:0] LCL_WDATA,
  input  logic [DATA_W-1:0] LCL_RDATA,
  input  logic              LCL_ACK
);

  logic              as_s, uds_s, lds_s, rw_s;
  logic [ADDR_W-1:0] a_s;
  logic [DATA_W-1:0] d_s;

  bus_sync #(.W(4)) u_sync_strb (
    .clk_sys (PI_CLK),
    .rst_n   (M68K_RESET_n),
    .d       ({M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW}),
    .q       ({as_s, uds_s, lds_s, rw_s})
  );

  bus_sync #(.W(ADDR_W + DATA_W)) u_sync_ad (
    .clk_sys (PI_CLK),
    .rst_n   (M68K_RESET_n),
    .d       ({M68K_A, M68K_D_IN}),
    .q       ({a_s, d_s})
  );

  bus_state_e        state_q, state_d;
  logic [9:0]        tcnt_q, tcnt_d, tcnt_dec;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              abort_q, abort_d;
  logic              req_q, req_d;
  logic              dtack_n_q, dtack_n_d;
  logic              dtack_oe_q, dtack_oe_d;
  logic              berr_n_q, berr_n_d;
  logic              we_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, dout_q;
  logic              latch_en, cap_rd;
  logic              strb_s, hit, timed_out;

  assign strb_s    = !uds_s || !lds_s;
  assign hit       = addr_hit(a_s, BASE_ADDR, ADDR_MASK);
  assign timed_out = (tcnt_q == 10'd1);
  assign tcnt_dec  = (tcnt_q != 10'd0) ? tcnt_q - 10'd1 : 10'd0;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    wcnt_d     = wcnt_q;
    abort_d    = abort_q;
    req_d      = req_q;
    dtack_n_d  = dtack_n_q;
    dtack_oe_d = dtack_oe_q;
    berr_n_d   = berr_n_q;
    latch_en   = 1'b0;
    cap_rd     = 1'b0;

    // a late ACK after timeout or abort still retires the request
    if (LCL_ACK) req_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!as_s && !req_q) begin
          if (hit) begin
            tcnt_d  = 10'(TIMEOUT);
            abort_d = 1'b0;
            if (strb_s) begin
              latch_en = 1'b1;
              req_d    = 1'b1;
              state_d  = ST_ACCESS;
            end else begin
              state_d = ST_STROBE;
            end
          end else begin
            state_d = ST_IGNORE;
          end
        end
      end
      ST_IGNORE: begin
        if (as_s) state_d = ST_IDLE;
      end
      ST_STROBE: begin
        tcnt_d = tcnt_dec;
        if (as_s) begin
          state_d = ST_IDLE;
        end else if (timed_out) begin
          berr_n_d = 1'b0;
          state_d  = ST_BERR;
        end else if (strb_s) begin
          latch_en = 1'b1;
          req_d    = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        tcnt_d = tcnt_dec;
        if (as_s) abort_d = 1'b1;
        if (LCL_ACK) begin
          if (abort_q || as_s) begin
            state_d = ST_IDLE;
          end else begin
            cap_rd  = !we_q;
            wcnt_d  = 4'(MIN_WAIT);
            state_d = ST_WAIT;
          end
        end else if (!as_s && !abort_q && timed_out) begin
          berr_n_d = 1'b0;
          state_d  = ST_BERR;
        end
      end
      ST_WAIT: begin
        tcnt_d = tcnt_dec;
        if (as_s) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd0) begin
          dtack_n_d  = 1'b0;
          dtack_oe_d = 1'b1;
          state_d    = ST_HOLD;
        end else if (timed_out) begin
          berr_n_d = 1'b0;
          state_d  = ST_BERR;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (as_s) begin
          dtack_n_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        dtack_oe_d = 1'b0;
        state_d    = ST_IDLE;
      end
      ST_BERR: begin
        if (as_s) begin
          berr_n_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PI_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      wcnt_q     <= '0;
      abort_q    <= 1'b0;
      req_q      <= 1'b0;
      dtack_n_q  <= 1'b1;
      dtack_oe_q <= 1'b0;
      berr_n_q   <= 1'b1;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      wcnt_q     <= wcnt_d;
      abort_q    <= abort_d;
      req_q      <= req_d;
      dtack_n_q  <= dtack_n_d;
      dtack_oe_q <= dtack_oe_d;
      berr_n_q   <= berr_n_d;
      if (latch_en) begin
        we_q    <= !rw_s;
        be_q    <= {!uds_s, !lds_s};
        addr_q  <= a_s;
        wdata_q <= d_s;
      end
      if (cap_rd) dout_q <= LCL_RDATA;
    end
  end

  // data drive follows the synchronised AS directly so it drops with AS_s
  assign M68K_D_OE     = !we_q && ((state_q == ST_WAIT) || (state_q == ST_HOLD)) && !as_s;
  assign M68K_D_OUT    = dout_q;
  assign M68K_DTACK_n  = dtack_n_q;
  assign M68K_DTACK_OE = dtack_oe_q;
  assign M68K_BERR_n   = berr_n_q;
  assign LCL_REQ       = req_q;
  assign LCL_WE        = we_q;
  assign LCL_BE        = be_q;
  assign LCL_ADDR      = addr_q;
  assign LCL_WDATA     = wdata_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: read/write hits, miss, timeout,
// aborted access and asynchronous reset during DTACK hold.
module tb_m68k_bus_responder;

  logic        PI_CLK = 1'b0;
  logic        M68K_RESET_n;
  logic [22:0] M68K_A;
  logic        M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW;
  logic [15:0] M68K_D_IN;
  logic [15:0] M68K_D_OUT;
  logic        M68K_D_OE, M68K_DTACK_n, M68K_DTACK_OE, M68K_BERR_n;
  logic        LCL_REQ, LCL_WE;
  logic [1:0]  LCL_BE;
  logic [22:0] LCL_ADDR;
  logic [15:0] LCL_WDATA, LCL_RDATA;
  logic        LCL_ACK;

  m68k_bus_responder dut (
    .PI_CLK        (PI_CLK),
    .M68K_RESET_n  (M68K_RESET_n),
    .M68K_A        (M68K_A),
    .M68K_AS_n     (M68K_AS_n),
    .M68K_UDS_n    (M68K_UDS_n),
    .M68K_LDS_n    (M68K_LDS_n),
    .M68K_RW       (M68K_RW),
    .M68K_D_IN     (M68K_D_IN),
    .M68K_D_OUT    (M68K_D_OUT),
    .M68K_D_OE     (M68K_D_OE),
    .M68K_DTACK_n  (M68K_DTACK_n),
    .M68K_DTACK_OE (M68K_DTACK_OE),
    .M68K_BERR_n   (M68K_BERR_n),
    .LCL_REQ       (LCL_REQ),
    .LCL_WE        (LCL_WE),
    .LCL_BE        (LCL_BE),
    .LCL_ADDR      (LCL_ADDR),
    .LCL_WDATA     (LCL_WDATA),
    .LCL_RDATA     (LCL_RDATA),
    .LCL_ACK       (LCL_ACK)
  );

  always #5 PI_CLK = ~PI_CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int e, req_e, dt_e, berr_e;
  logic flag_a, flag_b, flag_c;
  logic [23:0] waddr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge PI_CLK);
    #1;
  endtask

  task automatic pins_idle();
    M68K_AS_n  = 1'b1;
    M68K_UDS_n = 1'b1;
    M68K_LDS_n = 1'b1;
    M68K_RW    = 1'b1;
  endtask

  task automatic start_read(input logic [23:0] addr);
    M68K_A     = addr[23:1];
    M68K_RW    = 1'b1;
    M68K_AS_n  = 1'b0;
    M68K_UDS_n = 1'b0;
    M68K_LDS_n = 1'b0;
  endtask

  // full read cycle; ack_lat = cycles from LCL_REQ visible to ACK sampled
  task automatic do_read(input logic [23:0] addr, input logic [15:0] rdata,
                         input int ack_lat, input int exp_lat);
    int ce, cr, cd;
    ce = 0; cr = -1; cd = -1;
    start_read(addr);
    while (cd < 0 && ce < 60) begin
      tick();
      ce++;
      if (cr < 0 && LCL_REQ) begin
        cr = ce;
        check_val("rd_be", 32'(LCL_BE), 32'h3);
        check_val("rd_we", 32'(LCL_WE), 32'h0);
        check_val("rd_addr", 32'(LCL_ADDR), 32'(addr[23:1]));
      end
      if (!M68K_DTACK_n) cd = ce;
      if (cr > 0 && ce == cr + ack_lat - 1) begin
        LCL_ACK = 1'b1; LCL_RDATA = rdata;
      end else begin
        LCL_ACK = 1'b0; LCL_RDATA = 16'h0;
      end
    end
    LCL_ACK = 1'b0; LCL_RDATA = 16'h0;
    check_val("rd_req_lat", 32'(cr), 32'd3);
    check_val("rd_dtack_lat", 32'(cd), 32'(exp_lat));
    check_val("rd_dtack_oe", 32'(M68K_DTACK_OE), 32'h1);
    check_val("rd_dout", 32'(M68K_D_OUT), 32'(rdata));
    check_val("rd_doe", 32'(M68K_D_OE), 32'h1);
    tick(); tick();
    pins_idle();
    tick();
    check_val("rel1_doe", 32'(M68K_D_OE), 32'h1);
    tick();
    check_val("rel2_doe", 32'(M68K_D_OE), 32'h0);
    check_val("rel2_dtack", 32'(M68K_DTACK_n), 32'h0);
    tick();
    check_val("rel3_dtack", 32'(M68K_DTACK_n), 32'h1);
    check_val("rel3_dtack_oe", 32'(M68K_DTACK_OE), 32'h1);
    tick();
    check_val("rel4_dtack_oe", 32'(M68K_DTACK_OE), 32'h0);
    tick(); tick();
  endtask

  initial begin
    M68K_RESET_n = 1'b0;
    M68K_A = '0; M68K_D_IN = '0;
    LCL_RDATA = '0; LCL_ACK = 1'b0;
    pins_idle();
    tick(); tick();

    check_val("rst_dtack_n", 32'(M68K_DTACK_n), 32'h1);
    check_val("rst_dtack_oe", 32'(M68K_DTACK_OE), 32'h0);
    check_val("rst_berr_n", 32'(M68K_BERR_n), 32'h1);
    check_val("rst_doe", 32'(M68K_D_OE), 32'h0);
    check_val("rst_dout", 32'(M68K_D_OUT), 32'h0);
    check_val("rst_lcl", {LCL_REQ, LCL_WE, LCL_BE, 28'h0}, 32'h0);
    check_val("rst_addr", 32'(LCL_ADDR), 32'h0);
    check_val("rst_wdata", 32'(LCL_WDATA), 32'h0);
    M68K_RESET_n = 1'b1;
    repeat (3) tick();

    // read hit, ack latency 3, MIN_WAIT 2 -> DTACK 9 cycles after AS
    do_read(24'hE80010, 16'hBEEF, 3, 9);

    // write, UDS only, strobe 20 cycles after AS
    waddr = 24'hE80020;
    M68K_A = waddr[23:1];
    M68K_RW = 1'b0;
    M68K_D_IN = 16'h12A5;
    M68K_AS_n = 1'b0;
    flag_a = 1'b0; flag_b = 1'b0;
    repeat (20) begin
      tick();
      flag_a |= LCL_REQ;
      flag_b |= M68K_D_OE;
    end
    M68K_UDS_n = 1'b0;
    e = 0; req_e = -1;
    while (req_e < 0 && e < 10) begin
      tick(); e++;
      flag_b |= M68K_D_OE;
      if (LCL_REQ) req_e = e;
    end
    check_val("wr_early_req", 32'(flag_a), 32'h0);
    check_val("wr_req_lat", 32'(req_e), 32'd3);
    check_val("wr_be", 32'(LCL_BE), 32'h2);
    check_val("wr_wdata", 32'(LCL_WDATA), 32'h12A5);
    check_val("wr_we", 32'(LCL_WE), 32'h1);
    check_val("wr_addr", 32'(LCL_ADDR), 32'(waddr[23:1]));
    e = 0; dt_e = -1;
    LCL_ACK = 1'b1;
    while (dt_e < 0 && e < 12) begin
      tick(); e++;
      LCL_ACK = 1'b0;
      flag_b |= M68K_D_OE;
      if (!M68K_DTACK_n) dt_e = e;
    end
    check_val("wr_dtack_lat", 32'(dt_e), 32'd4);
    tick();
    pins_idle();
    repeat (4) begin
      tick();
      flag_b |= M68K_D_OE;
    end
    check_val("wr_doe_never", 32'(flag_b), 32'h0);
    check_val("wr_dtack_oe_rel", 32'(M68K_DTACK_OE), 32'h0);
    tick(); tick();

    // miss
    start_read(24'h000400);
    flag_a = 1'b0;
    repeat (15) begin
      tick();
      flag_a |= LCL_REQ | M68K_DTACK_OE | !M68K_BERR_n;
    end
    pins_idle();
    repeat (4) begin
      tick();
      flag_a |= LCL_REQ | M68K_DTACK_OE | !M68K_BERR_n;
    end
    check_val("miss_quiet", 32'(flag_a), 32'h0);
    do_read(24'hE8FFFE, 16'h5A5A, 1, 7);

    // ACK withheld -> BERR at 255 cycles after AS seen (pin edge + 3)
    start_read(24'hE80100);
    e = 0; berr_e = -1; flag_a = 1'b0;
    while (berr_e < 0 && e < 400) begin
      tick(); e++;
      flag_a |= M68K_DTACK_OE;
      if (!M68K_BERR_n) berr_e = e;
    end
    check_val("to_berr_lat", 32'(berr_e), 32'd258);
    check_val("to_req_held", 32'(LCL_REQ), 32'h1);
    repeat (5) tick();
    check_val("to_berr_hold", 32'(M68K_BERR_n), 32'h0);
    LCL_ACK = 1'b1;
    tick();
    LCL_ACK = 1'b0;
    check_val("to_late_ack", 32'(LCL_REQ), 32'h0);
    pins_idle();
    tick(); tick();
    flag_a |= M68K_DTACK_OE;
    check_val("to_berr_still", 32'(M68K_BERR_n), 32'h0);
    tick();
    check_val("to_berr_rel", 32'(M68K_BERR_n), 32'h1);
    check_val("to_no_dtack", 32'(flag_a), 32'h0);
    tick(); tick();

    // AS released while ACCESS -> REQ held to ACK, no termination
    start_read(24'hE80040);
    e = 0; req_e = -1;
    while (req_e < 0 && e < 10) begin
      tick(); e++;
      if (LCL_REQ) req_e = e;
    end
    pins_idle();
    flag_a = 1'b1;
    repeat (6) begin
      tick();
      flag_a &= LCL_REQ;
    end
    check_val("ab_req_held", 32'(flag_a), 32'h1);
    LCL_ACK = 1'b1; LCL_RDATA = 16'hDEAD;
    tick();
    LCL_ACK = 1'b0; LCL_RDATA = 16'h0;
    check_val("ab_req_drop", 32'(LCL_REQ), 32'h0);
    flag_b = 1'b0;
    repeat (10) begin
      tick();
      flag_b |= M68K_DTACK_OE | !M68K_BERR_n | M68K_D_OE | LCL_REQ;
    end
    check_val("ab_quiet", 32'(flag_b), 32'h0);
    check_val("ab_dout_kept", 32'(M68K_D_OUT), 32'h5A5A);

    // async reset while in HOLD
    start_read(24'hE80002);
    e = 0; req_e = -1;
    while (req_e < 0 && e < 10) begin
      tick(); e++;
      if (LCL_REQ) req_e = e;
    end
    LCL_ACK = 1'b1; LCL_RDATA = 16'h7777;
    tick();
    LCL_ACK = 1'b0; LCL_RDATA = 16'h0;
    e = 0; dt_e = -1;
    while (dt_e < 0 && e < 12) begin
      tick(); e++;
      if (!M68K_DTACK_n) dt_e = e;
    end
    check_val("rs_pre_doe", 32'(M68K_D_OE), 32'h1);
    #2;
    M68K_RESET_n = 1'b0;
    #1;
    check_val("rs_dtack_oe", 32'(M68K_DTACK_OE), 32'h0);
    check_val("rs_doe", 32'(M68K_D_OE), 32'h0);
    check_val("rs_dtack_n", 32'(M68K_DTACK_n), 32'h1);
    check_val("rs_req", 32'(LCL_REQ), 32'h0);
    check_val("rs_dout", 32'(M68K_D_OUT), 32'h0);
    pins_idle();
    tick(); tick();
    M68K_RESET_n = 1'b1;
    tick(); tick();
    do_read(24'hE80010, 16'hC3C3, 3, 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
